// File: rtl/lcd_pkg.sv
// Shared constants and types for the HD44780 row-update sequencer.
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWR,
        S_INIT,
        S_CLR,
        S_IDLE,
        S_ADDR,
        S_CHAR,
        S_WAIT
    } state_t;

    // 4-bit mode bring-up: 0x33/0x32 force nibble mode, then function set,
    // display on, entry mode, clear. Entry [0] is sent first.
    localparam int INIT_LEN = 6;
    localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {8'h01, 8'h06, 8'h0C, 8'h28, 8'h32, 8'h33};

    localparam logic [7:0] LCD_CMD_SET_DDRAM = 8'h80;
    localparam logic [7:0] LCD_CHAR_SPACE    = 8'h20;
    localparam logic [7:0] ROW_OFFSET_1      = 8'h40;

    // Set-DDRAM command for the first column of a row. Rows 2/3 continue
    // rows 0/1 in DDRAM, so they sit COLS past the row 0/1 bases.
    function automatic logic [7:0] row_addr_cmd(input logic [1:0] row, input int cols);
        logic [7:0] base;
        base = row[0] ? ROW_OFFSET_1 : 8'h00;
        if (row[1]) base = base + 8'(cols);
        return LCD_CMD_SET_DDRAM | base;
    endfunction

endpackage

// File: rtl/lcd_row_dirty.sv
// Per-row change detector: a row is dirty when the frame differs from what
// the display shows or when a rewrite was forced. Lowest dirty row wins.
module lcd_row_dirty
    import lcd_pkg::*;
#(
    parameter int ROWS = 2,
    parameter int COLS = 16,
    parameter int RW   = 1
) (
    input  logic [ROWS*COLS*8-1:0]       frame,
    input  logic [ROWS-1:0][COLS*8-1:0]  shown,
    input  logic [ROWS-1:0]              force_rows,
    output logic [RW-1:0]                dirty_idx,
    output logic                         any_dirty
);

    logic [ROWS-1:0] dirty;

    // Row 0 occupies the most significant bytes of the frame.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign dirty[r] = (frame[(ROWS-1-r)*COLS*8 +: COLS*8] != shown[r]) || force_rows[r];
    end

    // Priority encode from the top down so the lowest index is left standing.
    always_comb begin
        dirty_idx = '0;
        any_dirty = |dirty;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (dirty[r]) dirty_idx = RW'(r);
        end
    end

endmodule

// File: rtl/lcd_display_multi.sv
// HD44780 sequencer for the PCF8574 backpack: power-up init, then rewrites
// only rows whose content changed, with an optional periodic full refresh.
module lcd_display_multi
    import lcd_pkg::*;
#(
    parameter int ROWS        = 2,
    parameter int COLS        = 16,
    parameter int POWERUP_CYC = 50000,
    parameter int CLEAR_CYC   = 2000,
    parameter int REFRESH_CYC = 0
) (
    input  logic                   clk_1MHz,
    input  logic                   rst,
    input  logic                   ena,
    input  logic [ROWS*COLS*8-1:0] frame,
    input  logic                   done_write,
    output logic [7:0]             data,
    output logic                   cmd_data,
    output logic                   ena_write,
    output logic                   init_done,
    output logic                   busy
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [31:0] PWR_N = POWERUP_CYC;
    localparam logic [31:0] CLR_N = CLEAR_CYC;
    localparam logic [31:0] REF_N = REFRESH_CYC;

    if (ROWS < 1 || ROWS > 4) begin : g_bad_rows
        $error("lcd_display_multi: ROWS must be 1..4");
    end
    if (COLS < 1 || COLS > 40) begin : g_bad_cols
        $error("lcd_display_multi: COLS must be 1..40");
    end

    state_t                      state, state_next, ret_state;
    logic [31:0]                 cnt, rcnt;
    logic [2:0]                  init_idx;
    logic [CW-1:0]               col;
    logic [RW-1:0]               row_sel;
    logic [COLS*8-1:0]           snap;
    logic [ROWS-1:0][COLS*8-1:0] shown;
    logic [ROWS-1:0]             force_rows;
    logic [7:0]                  data_q;
    logic                        cmd_q, req_q, init_done_q;
    logic [RW-1:0]               dirty_idx;
    logic                        any_dirty;
    logic                        last_col;
    logic [7:0]                  cur_char;

    lcd_row_dirty #(.ROWS(ROWS), .COLS(COLS), .RW(RW)) u_dirty (
        .frame      (frame),
        .shown      (shown),
        .force_rows (force_rows),
        .dirty_idx  (dirty_idx),
        .any_dirty  (any_dirty)
    );

    assign last_col = (col == CW'(COLS - 1));
    assign cur_char = snap[(COLS-1-int'(col))*8 +: 8];

    // State register plus the datapath that moves with each transition.
    always_ff @(posedge clk_1MHz) begin
        if (rst) begin
            state       <= S_PWR;
            ret_state   <= S_PWR;
            cnt         <= '0;
            rcnt        <= '0;
            init_idx    <= '0;
            col         <= '0;
            row_sel     <= '0;
            snap        <= {COLS{LCD_CHAR_SPACE}};
            shown       <= {(ROWS*COLS){LCD_CHAR_SPACE}};
            force_rows  <= '1;
            data_q      <= 8'h00;
            cmd_q       <= 1'b0;
            req_q       <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state <= state_next;
            req_q <= 1'b0;

            // One delay counter serves both timed states; it restarts on entry.
            if ((state == S_PWR || state == S_CLR) && state_next == state) cnt <= cnt + 32'd1;
            else cnt <= '0;

            case (state)
                S_INIT: begin
                    data_q    <= INIT_CMDS[init_idx];
                    cmd_q     <= 1'b0;
                    req_q     <= 1'b1;
                    ret_state <= (init_idx == 3'(INIT_LEN - 1)) ? S_CLR : S_INIT;
                    init_idx  <= init_idx + 3'd1;
                end
                S_CLR: if (state_next == S_IDLE) init_done_q <= 1'b1;
                S_IDLE: if (state_next == S_ADDR) begin
                    // Snapshot so later frame edits cannot tear this row.
                    row_sel <= dirty_idx;
                    snap    <= frame[(ROWS-1-int'(dirty_idx))*COLS*8 +: COLS*8];
                end
                S_ADDR: begin
                    data_q    <= row_addr_cmd(2'(row_sel), COLS);
                    cmd_q     <= 1'b0;
                    req_q     <= 1'b1;
                    ret_state <= S_CHAR;
                    col       <= '0;
                end
                S_CHAR: begin
                    data_q    <= cur_char;
                    cmd_q     <= 1'b1;
                    req_q     <= 1'b1;
                    ret_state <= last_col ? S_IDLE : S_CHAR;
                    if (!last_col) col <= col + CW'(1);
                end
                S_WAIT: if (done_write && ret_state == S_IDLE) begin
                    // Row finished: the display now holds the snapshot.
                    shown[row_sel]      <= snap;
                    force_rows[row_sel] <= 1'b0;
                end
                default: ;
            endcase

            // Refresh sits after the row-complete clear so a coincident expiry still forces.
            if (REFRESH_CYC > 0 && init_done_q) begin
                if (rcnt + 32'd1 >= REF_N) begin
                    rcnt       <= '0;
                    force_rows <= '1;
                end else begin
                    rcnt <= rcnt + 32'd1;
                end
            end
        end
    end

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            S_PWR:                  if (cnt + 32'd1 >= PWR_N) state_next = S_INIT;
            S_INIT, S_ADDR, S_CHAR: state_next = S_WAIT;
            S_CLR:                  if (cnt + 32'd1 >= CLR_N) state_next = S_IDLE;
            S_IDLE:                 if (ena && any_dirty) state_next = S_ADDR;
            S_WAIT:                 if (done_write) state_next = ret_state;
            default:                state_next = S_PWR;
        endcase
    end

    // Outputs: registered request fields plus state-decoded busy.
    always_comb begin
        data      = data_q;
        cmd_data  = cmd_q;
        ena_write = req_q;
        init_done = init_done_q;
        busy      = (state != S_IDLE);
    end

endmodule

// File: tb/tb_lcd_display_multi.sv
// Directed bench: 16x2 instance for init/row/gating/reset, 20x4 for refresh.
module tb_lcd_display_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_a = 1'b1, ena_a = 1'b1, done_a;
    logic [255:0] frame_a, f1;
    logic [7:0]   d_a;
    logic         cd_a, ew_a, id_a, busy_a;

    logic         rst_b = 1'b1, ena_b = 1'b1, done_b;
    logic [639:0] frame_b;
    logic [7:0]   d_b;
    logic         cd_b, ew_b, id_b, busy_b;

    int n_chk = 0, n_err = 0, gcyc = 0;
    int prot_a, prot_b, cnt_wa, cnt_wb, done_edge_a;
    logic prev_ew_a, prev_ew_b;
    logic [8:0] last_a, last_b;
    logic [8:0] log_a[$], exp_a[$];
    logic [7:0] cmd_b[$];
    logic [7:0] init_cmds[6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};
    logic [7:0] exp_b[18];
    int first, rise, run;

    lcd_display_multi #(.ROWS(2), .COLS(16), .POWERUP_CYC(20), .CLEAR_CYC(10), .REFRESH_CYC(0)) u_dut_a (
        .clk_1MHz(clk), .rst(rst_a), .ena(ena_a), .frame(frame_a), .done_write(done_a),
        .data(d_a), .cmd_data(cd_a), .ena_write(ew_a), .init_done(id_a), .busy(busy_a));

    lcd_display_multi #(.ROWS(4), .COLS(20), .POWERUP_CYC(20), .CLEAR_CYC(10), .REFRESH_CYC(3000)) u_dut_b (
        .clk_1MHz(clk), .rst(rst_b), .ena(ena_b), .frame(frame_b), .done_write(done_b),
        .data(d_b), .cmd_data(cd_b), .ena_write(ew_b), .init_done(id_b), .busy(busy_b));

    always @(posedge clk) gcyc <= gcyc + 1;

    // Byte writer model A: answers 5 cycles after each request, logs bytes, checks handshake.
    always @(posedge clk) begin
        #1;
        if (rst_a) begin
            cnt_wa = 0; done_a = 1'b0; prev_ew_a = 1'b0;
        end else begin
            if (ew_a) begin
                if (cnt_wa > 0 || done_a || prev_ew_a) prot_a++;
                log_a.push_back({cd_a, d_a});
                last_a = {cd_a, d_a};
            end else if ((cnt_wa > 0 || done_a) && {cd_a, d_a} != last_a) prot_a++;
            prev_ew_a = ew_a;
            if (cnt_wa > 0) begin
                cnt_wa--;
                done_a = (cnt_wa == 0);
                if (done_a) done_edge_a = gcyc + 1;
            end else done_a = 1'b0;
            if (ew_a) cnt_wa = 5;
        end
    end

    // Byte writer model B: same timing, keeps only command bytes.
    always @(posedge clk) begin
        #1;
        if (rst_b) begin
            cnt_wb = 0; done_b = 1'b0; prev_ew_b = 1'b0;
        end else begin
            if (ew_b) begin
                if (cnt_wb > 0 || done_b || prev_ew_b) prot_b++;
                if (!cd_b) cmd_b.push_back(d_b);
                last_b = {cd_b, d_b};
            end else if ((cnt_wb > 0 || done_b) && {cd_b, d_b} != last_b) prot_b++;
            prev_ew_b = ew_b;
            if (cnt_wb > 0) begin
                cnt_wb--;
                done_b = (cnt_wb == 0);
            end else done_b = 1'b0;
            if (ew_b) cnt_wb = 5;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic exp_init_a();
        for (int i = 0; i < 6; i++) exp_a.push_back({1'b0, init_cmds[i]});
    endtask

    task automatic exp_row_a(input logic [255:0] fr, input int r, input logic [7:0] addr);
        logic [7:0] ch;
        exp_a.push_back({1'b0, addr});
        for (int c = 0; c < 16; c++) begin
            ch = fr[(31 - (r*16 + c))*8 +: 8];
            exp_a.push_back({1'b1, ch});
        end
    endtask

    task automatic cmp_log_a(input string tag);
        chk({tag, "_len"}, 32'(log_a.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < log_a.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), 32'(log_a[i]), 32'(exp_a[i]));
    endtask

    task automatic clear_a();
        log_a.delete();
        exp_a.delete();
    endtask

    // Idle means busy low for 3 samples running; between rows it dips for only one.
    task automatic wait_idle_a(input string tag, input int bound);
        int r;
        r = 0;
        for (int i = 0; i < bound && r < 3; i++) begin
            @(negedge clk);
            r = busy_a ? 0 : r + 1;
        end
        chk({tag, "_idle"}, 32'(r >= 3), 32'd1);
    endtask

    task automatic wait_log_a(input string tag, input int n, input int bound);
        for (int i = 0; i < bound && log_a.size() < n; i++) @(negedge clk);
        chk({tag, "_reached"}, 32'(log_a.size() >= n), 32'd1);
    endtask

    initial begin
        prot_a = 0; prot_b = 0;
        frame_a = {" Happy New Year ", "      2025      "};
        frame_b = {"ABCDEFGHIJKLMNOPQRST", "abcdefghijklmnopqrst",
                   "0123456789abcdefghij", "klmnopqrstuvwxyz!@#$"};
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_ena_write", 32'(ew_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd1);
        chk("rst_init_done", 32'(id_a), 32'd0);
        chk("rst_data", 32'(d_a), 32'h00);
        chk("rst_cmd_data", 32'(cd_a), 32'd0);

        // Init timing and command table
        rst_a = 1'b0;
        first = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ew_a) begin first = k; break; end
        end
        chk("first_req_cycle", 32'(first), 32'd20);
        rise = -1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (id_a) begin rise = gcyc; break; end
        end
        chk("init_done_lat", 32'(rise - done_edge_a), 32'd10);
        exp_init_a();
        cmp_log_a("init");
        clear_a();

        // First frame: both rows (all force bits set out of reset)
        exp_row_a(frame_a, 0, 8'h80);
        exp_row_a(frame_a, 1, 8'hC0);
        wait_idle_a("frame1", 2000);
        cmp_log_a("frame1");
        chk("row0_char0", 32'(log_a[1]), 32'h120);
        chk("row0_char1", 32'(log_a[2]), 32'h148);
        chk("frame1_busy", 32'(busy_a), 32'd0);

        // Partial update: only row 1
        clear_a();
        frame_a[127:0] = "      2026      ";
        exp_row_a(frame_a, 1, 8'hC0);
        wait_idle_a("partial", 1000);
        cmp_log_a("partial");

        // Mid-row change: snapshot written first, then the new data
        clear_a();
        frame_a[255:128] = "Hello World 2026";
        f1 = frame_a;
        wait_log_a("midrow_5th", 6, 500);
        frame_a[255:128] = "Second snapshot!";
        exp_row_a(f1, 0, 8'h80);
        exp_row_a(frame_a, 0, 8'h80);
        wait_idle_a("midrow", 2000);
        cmp_log_a("midrow");

        // ena gating: dirty row waits while ena is low
        clear_a();
        ena_a = 1'b0;
        frame_a[127:0] = "      2027      ";
        repeat (150) @(negedge clk);
        chk("gated_reqs", 32'(log_a.size()), 32'd0);
        chk("gated_busy", 32'(busy_a), 32'd0);
        ena_a = 1'b1;
        exp_row_a(frame_a, 1, 8'hC0);
        wait_idle_a("ungated", 1000);
        cmp_log_a("ungated");

        // Reset while a row is being written
        clear_a();
        frame_a[255:128] = "Reset test row 0";
        wait_log_a("rst_row", 3, 500);
        run = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done_a) begin run = 1; break; end
        end
        chk("rst_done_seen", 32'(run), 32'd1);
        @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk("midrst_ena_write", 32'(ew_a), 32'd0);
        chk("midrst_busy", 32'(busy_a), 32'd1);
        chk("midrst_init_done", 32'(id_a), 32'd0);
        repeat (2) @(negedge clk);
        clear_a();
        rst_a = 1'b0;
        exp_init_a();
        exp_row_a(frame_a, 0, 8'h80);
        exp_row_a(frame_a, 1, 8'hC0);
        wait_idle_a("replay", 4000);
        cmp_log_a("replay");
        chk("replay_init_done", 32'(id_a), 32'd1);

        // 20x4 with refresh: addresses recur after every expiry
        for (int i = 0; i < 6; i++) exp_b[i] = init_cmds[i];
        for (int p = 0; p < 3; p++) begin
            exp_b[6 + p*4]     = 8'h80;
            exp_b[6 + p*4 + 1] = 8'hC0;
            exp_b[6 + p*4 + 2] = 8'h94;
            exp_b[6 + p*4 + 3] = 8'hD4;
        end
        rst_b = 1'b0;
        for (int i = 0; i < 12000 && cmd_b.size() < 18; i++) @(negedge clk);
        chk("refresh_cmd_count", 32'(cmd_b.size()), 32'd18);
        for (int i = 0; i < 18 && i < cmd_b.size(); i++)
            chk($sformatf("refresh_cmd[%0d]", i), 32'(cmd_b[i]), 32'(exp_b[i]));

        chk("handshake_a", 32'(prot_a), 32'd0);
        chk("handshake_b", 32'(prot_b), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
